mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 256x16 RAM between two requesters: the CPU (controller/datapath) and an external IO/DMA port.
- Grants one requester at a time, holds RAM address, data and write strobe stable for a fixed access window, then returns a registered read word with a one-cycle ack pulse.
- Sits between the requesters and the RAM; the RAM-side ports replace the direct datapath-to-RAM connection in the CPU top.

Parameters:
AW, 8, address width
DW, 16, data width
ACC_CYC, 2, cycles the RAM signals are held per access (legal range 1..15)
CPU_PRIO, 0, 0 = round-robin on tie; 1 = CPU always wins a tie

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (rst=0 at a rising clk edge resets)
cpu_req  in  1  CPU access request
cpu_rw  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  read data, valid in the cpu_ack cycle
io_req  in  1  IO access request
io_rw  in  1  1 = write, 0 = read
io_addr  in  AW  IO address
io_wdata  in  DW  IO write data
io_ack  out  1  one-cycle completion pulse
io_rdata  out  DW  read data, valid in the io_ack cycle
busy  out  1  high while an access is in flight
MemRW  out  1  RAM write strobe, 1 = write
MemAddr  out  AW  RAM address
MemD  out  DW  RAM write data
MemQ  in  DW  RAM read data (combinational from MemAddr)

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge): state=IDLE; every ack=0; busy=0; MemRW=0; MemAddr=0; MemD=0; cpu_rdata=0; io_rdata=0; cnt=0; last_owner=IO, so the CPU wins the first tie.
- Reset wins over any in-flight access. The access is abandoned with no ack, and MemRW drops in the same edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE; MemRW=0; MemAddr/MemD hold their last values.
- IDLE, requests present: choose an owner.
  - Only one req high: grant that requester.
  - Both high with CPU_PRIO=1: grant the CPU.
  - Both high with CPU_PRIO=0: grant the requester that is not last_owner.
- On grant:
  - Latch the owner's addr into MemAddr, wdata into MemD and rw into MemRW.
  - Set busy=1 and cnt=ACC_CYC-1; go to ACCESS.
- ACCESS:
  - Hold MemAddr, MemD and MemRW constant.
  - While cnt!=0, decrement cnt.
  - When cnt==0:
    - If the access is a read, capture MemQ into the owner's rdata register.
    - Drive MemRW=0, pulse the owner's ack=1 and update last_owner to the owner.
    - Go to DONE.
- DONE (one cycle):
  - The ack is high in this cycle, rdata is valid and busy is still 1.
  - The arbiter ignores every req sampled in this cycle, so a held req is not reissued with stale fields.
  - At the next edge: ack=0, busy=0, go to IDLE.
- Timing:
  - A req sampled at edge N gives MemRW/MemAddr valid from N+1 through N+ACC_CYC.
  - The ack is high in cycle N+ACC_CYC+1.
  - Minimum spacing between successive grants is ACC_CYC+2 cycles.
- Requester protocol:
  - Hold req, rw, addr and wdata stable from assertion until ack.
  - Deassert req, or present the next access, in the cycle after ack.
- Dropping req mid-access is tolerated. The access still completes and ack still pulses.
- A write never updates rdata. The non-owner's ack and rdata are unaffected.
- Starvation: with CPU_PRIO=0 and both req held continuously, grants strictly alternate CPU, IO, CPU, and so on.

Test Plan:
- Reset: hold rst=0 for 3 cycles with cpu_req=1 -> all acks 0, MemRW=0, MemAddr=0, busy=0 throughout; after release, the CPU is granted first.
- CPU read: RAM[0x10]=0xBEEF, cpu_req=1, cpu_rw=0, cpu_addr=0x10, ACC_CYC=2 -> MemAddr=0x10 for 2 cycles with MemRW=0; cpu_ack is high exactly 1 cycle, 3 cycles after the sampled req, with cpu_rdata=0xBEEF.
- IO write: io_req=1, io_rw=1, io_addr=0x80, io_wdata=0x1234 -> MemRW=1 for exactly ACC_CYC cycles with MemD=0x1234; io_ack pulses once; a subsequent CPU read of 0x80 returns 0x1234.
- Tie, CPU_PRIO=0: both req held with 4 accesses each -> grant order CPU, IO, CPU, IO, CPU, IO, CPU, IO; no two consecutive acks go to the same port; with CPU_PRIO=1, all 4 CPU accesses complete first.
- Held req after ack: the CPU keeps req high in the ack cycle with the same fields -> no duplicate access in that cycle; the next grant starts at the earliest one cycle later (IDLE).
- Reset mid-access: assert rst=0 during the ACCESS cycle of an IO write -> MemRW=0 at the next edge, no io_ack, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: grants the CPU or the IO/DMA
// port, holds the RAM controls for ACC_CYC cycles, then returns a registered read word with an ack.
module mem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int ACC_CYC  = 2,
   parameter int CPU_PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_rw,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          io_req,
   input  logic          io_rw,
   input  logic [AW-1:0] io_addr,
   input  logic [DW-1:0] io_wdata,
   output logic          io_ack,
   output logic [DW-1:0] io_rdata,
   output logic          busy,
   output logic          MemRW,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemD,
   input  logic [DW-1:0] MemQ
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);
   localparam logic       OWN_CPU  = 1'b0;
   localparam logic       OWN_IO   = 1'b1;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            owner_q, owner_d;
   logic            last_owner_q, last_owner_d;
   logic            busy_q, busy_d;
   logic            cpu_ack_q, cpu_ack_d;
   logic            io_ack_q, io_ack_d;
   logic            mem_rw_q, mem_rw_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_d_q, mem_d_d;
   logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0]   io_rdata_q, io_rdata_d;
   logic            grant_io;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      busy_d       = busy_q;
      cpu_ack_d    = 1'b0;
      io_ack_d     = 1'b0;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_d_d      = mem_d_q;
      cpu_rdata_d  = cpu_rdata_q;
      io_rdata_d   = io_rdata_q;
      grant_io     = 1'b0;

      case (state_q)
         IDLE: begin
            mem_rw_d = 1'b0;
            if (cpu_req || io_req) begin
               // On a tie the IO port wins only in round-robin mode and only if the CPU went last.
               grant_io   = io_req && (!cpu_req || ((CPU_PRIO == 0) && (last_owner_q == OWN_CPU)));
               owner_d    = grant_io;
               mem_rw_d   = grant_io ? io_rw     : cpu_rw;
               mem_addr_d = grant_io ? io_addr   : cpu_addr;
               mem_d_d    = grant_io ? io_wdata  : cpu_wdata;
               busy_d     = 1'b1;
               cnt_d      = CNT_INIT;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!mem_rw_q) begin
                  if (owner_q == OWN_IO) io_rdata_d  = MemQ;
                  else                   cpu_rdata_d = MemQ;
               end
               if (owner_q == OWN_IO) io_ack_d  = 1'b1;
               else                   cpu_ack_d = 1'b1;
               mem_rw_d     = 1'b0;
               last_owner_d = owner_q;
               state_d      = DONE;
            end
         end
         DONE: begin
            // Requests seen here belong to the access just acked, so they are ignored.
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_IO;
         busy_q       <= 1'b0;
         cpu_ack_q    <= 1'b0;
         io_ack_q     <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_d_q      <= '0;
         cpu_rdata_q  <= '0;
         io_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         busy_q       <= busy_d;
         cpu_ack_q    <= cpu_ack_d;
         io_ack_q     <= io_ack_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_d_q      <= mem_d_d;
         cpu_rdata_q  <= cpu_rdata_d;
         io_rdata_q   <= io_rdata_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign io_ack    = io_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign io_rdata  = io_rdata_q;
   assign busy      = busy_q;
   assign MemRW     = mem_rw_q;
   assign MemAddr   = mem_addr_q;
   assign MemD      = mem_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic compared against a transaction-level model.
module tb_mem_arbiter;

   localparam int ACC   = 2;
   localparam int P_ACC = 3;

   logic        clk;
   logic        rst;
   logic        ram_clear;

   logic        cpu_req, cpu_rw, cpu_ack;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        io_req, io_rw, io_ack;
   logic [7:0]  io_addr;
   logic [15:0] io_wdata, io_rdata;
   logic        busy, mem_rw;
   logic [7:0]  mem_addr;
   logic [15:0] mem_d, mem_q;

   logic        p_cpu_req, p_cpu_rw, p_cpu_ack;
   logic [7:0]  p_cpu_addr;
   logic [15:0] p_cpu_wdata, p_cpu_rdata;
   logic        p_io_req, p_io_rw, p_io_ack;
   logic [7:0]  p_io_addr;
   logic [15:0] p_io_wdata, p_io_rdata;
   logic        p_busy, p_mem_rw;
   logic [7:0]  p_mem_addr;
   logic [15:0] p_mem_d, p_mem_q;

   logic [15:0] ram       [256];
   logic [15:0] model_mem [256];

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      bit          io;
      bit          rw;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } txn_t;

   mem_arbiter #(.AW(8), .DW(16), .ACC_CYC(ACC), .CPU_PRIO(0)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .io_req(io_req), .io_rw(io_rw), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_ack(io_ack), .io_rdata(io_rdata),
      .busy(busy), .MemRW(mem_rw), .MemAddr(mem_addr), .MemD(mem_d), .MemQ(mem_q)
   );

   mem_arbiter #(.AW(8), .DW(16), .ACC_CYC(P_ACC), .CPU_PRIO(1)) u_pri (
      .clk(clk), .rst(rst),
      .cpu_req(p_cpu_req), .cpu_rw(p_cpu_rw), .cpu_addr(p_cpu_addr), .cpu_wdata(p_cpu_wdata),
      .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
      .io_req(p_io_req), .io_rw(p_io_rw), .io_addr(p_io_addr), .io_wdata(p_io_wdata),
      .io_ack(p_io_ack), .io_rdata(p_io_rdata),
      .busy(p_busy), .MemRW(p_mem_rw), .MemAddr(p_mem_addr), .MemD(p_mem_d), .MemQ(p_mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
         ram[8'h10] <= 16'hBEEF;
         ram[8'h20] <= 16'h2020;
      end else if (mem_rw) begin
         ram[mem_addr] <= mem_d;
      end
   end

   assign mem_q   = ram[mem_addr];
   assign p_mem_q = {8'hC3, p_mem_addr};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit io, input int budget, output int n, output bit got);
      n = 0;
      got = 1'b0;
      while (!got && n < budget) begin
         tick();
         n++;
         got = io ? io_ack : cpu_ack;
      end
   endtask

   task automatic do_txn(input string nm, input txn_t t);
      int   k, addr_cyc, rw_cyc, d_cyc, other;
      bit   got;
      if (t.io) begin
         io_rw = t.rw; io_addr = t.addr; io_wdata = t.wdata; io_req = 1'b1;
      end else begin
         cpu_rw = t.rw; cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_req = 1'b1;
      end
      k = 0; addr_cyc = 0; rw_cyc = 0; d_cyc = 0; other = 0; got = 1'b0;
      while (!got && k < 20) begin
         tick();
         k++;
         got = t.io ? io_ack : cpu_ack;
         if ((t.io ? cpu_ack : io_ack) == 1'b1) other++;
         if (!got) begin
            if (mem_addr == t.addr) addr_cyc++;
            if (mem_rw) rw_cyc++;
            if (mem_rw && mem_d == t.wdata) d_cyc++;
         end
      end
      chk({nm, "_ack_seen"}, 32'(got), 32'd1);
      chk({nm, "_latency"}, 32'(k), 32'(ACC + 1));
      chk({nm, "_addr_cycles"}, 32'(addr_cyc), 32'(ACC));
      chk({nm, "_rw_cycles"}, 32'(rw_cyc), t.rw ? 32'(ACC) : 32'd0);
      chk({nm, "_memd_cycles"}, 32'(d_cyc), t.rw ? 32'(ACC) : 32'd0);
      chk({nm, "_other_ack"}, 32'(other), 32'd0);
      chk({nm, "_rdata"}, 32'(t.io ? io_rdata : cpu_rdata), 32'(t.exp_rdata));
      cpu_req = 1'b0;
      io_req  = 1'b0;
      tick();
      chk({nm, "_ack_pulse_end"}, 32'(cpu_ack | io_ack), 32'd0);
      chk({nm, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic run_tie();
      int ca, ia, pca, pia;
      int ord_rr[$];
      int ord_pr[$];
      ca = 0; ia = 0; pca = 0; pia = 0;
      cpu_rw = 1'b0; cpu_addr = 8'h30; cpu_wdata = 16'h0; cpu_req = 1'b1;
      io_rw  = 1'b0; io_addr  = 8'h90; io_wdata  = 16'h0; io_req  = 1'b1;
      p_cpu_rw = 1'b0; p_cpu_addr = 8'h30; p_cpu_wdata = 16'h0; p_cpu_req = 1'b1;
      p_io_rw  = 1'b0; p_io_addr  = 8'h90; p_io_wdata  = 16'h0; p_io_req  = 1'b1;
      for (int k = 0; k < 200 && (ord_rr.size() < 8 || ord_pr.size() < 8); k++) begin
         tick();
         if (cpu_ack) begin
            ord_rr.push_back(0); ca++;
            if (ca == 4) cpu_req = 1'b0; else cpu_addr = cpu_addr + 8'd1;
         end
         if (io_ack) begin
            ord_rr.push_back(1); ia++;
            if (ia == 4) io_req = 1'b0; else io_addr = io_addr + 8'd1;
         end
         if (p_cpu_ack) begin
            ord_pr.push_back(0); pca++;
            if (pca == 4) p_cpu_req = 1'b0; else p_cpu_addr = p_cpu_addr + 8'd1;
         end
         if (p_io_ack) begin
            ord_pr.push_back(1); pia++;
            if (pia == 4) p_io_req = 1'b0; else p_io_addr = p_io_addr + 8'd1;
         end
      end
      cpu_req = 1'b0; io_req = 1'b0; p_cpu_req = 1'b0; p_io_req = 1'b0;
      chk("tie_rr_count", 32'(ord_rr.size()), 32'd8);
      chk("tie_pri_count", 32'(ord_pr.size()), 32'd8);
      if (ord_rr.size() == 8)
         for (int i = 0; i < 8; i++) chk("tie_rr_order", 32'(ord_rr[i]), 32'(i % 2));
      if (ord_pr.size() == 8)
         for (int i = 0; i < 8; i++) chk("tie_pri_order", 32'(ord_pr[i]), (i < 4) ? 32'd0 : 32'd1);
      tick();
      tick();
      chk("tie_pri_cpu_rdata", 32'(p_cpu_rdata), 32'h0000C333);
      chk("tie_pri_io_rdata", 32'(p_io_rdata), 32'h0000C393);
      chk("tie_pri_idle", 32'({p_busy, p_mem_rw}), 32'd0);
      chk("tie_pri_memd", 32'(p_mem_d), 32'd0);
   endtask

   task automatic run_random();
      int          e, free_at, g_e;
      bit          act, own, c_rw, lo;
      logic [7:0]  c_addr;
      logic [15:0] c_wd, ecr, eir;
      bit          s_cr, s_crw, s_ir, s_irw;
      logic [7:0]  s_ca, s_ia;
      logic [15:0] s_cw, s_iw;
      bit          x_busy, x_rw, x_cack, x_iack;
      e = 0; free_at = 0; g_e = 0; act = 1'b0; own = 1'b0; c_rw = 1'b0; lo = 1'b1;
      c_addr = 8'h0; c_wd = 16'h0; ecr = 16'h0; eir = 16'h0;
      for (int i = 0; i < 256; i++) model_mem[i] = ram[i];
      cpu_req = 1'b0; io_req = 1'b0;
      for (int k = 0; k < 600; k++) begin
         s_cr = cpu_req; s_crw = cpu_rw; s_ca = cpu_addr; s_cw = cpu_wdata;
         s_ir = io_req;  s_irw = io_rw;  s_ia = io_addr;  s_iw = io_wdata;
         tick();
         e++;
         if (e >= free_at && (s_cr || s_ir)) begin
            own    = s_ir && (!s_cr || lo == 1'b0);
            c_rw   = own ? s_irw : s_crw;
            c_addr = own ? s_ia  : s_ca;
            c_wd   = own ? s_iw  : s_cw;
            act = 1'b1; g_e = e; free_at = e + ACC + 2;
         end
         x_busy = act && e >= g_e && e <= g_e + ACC;
         x_rw   = act && e < g_e + ACC && c_rw;
         x_cack = act && e == g_e + ACC && !own;
         x_iack = act && e == g_e + ACC && own;
         if (act && e == g_e + ACC) begin
            if (c_rw) model_mem[c_addr] = c_wd;
            else if (own) eir = model_mem[c_addr];
            else ecr = model_mem[c_addr];
            lo = own;
         end
         chk("rnd_busy", 32'(busy), 32'(x_busy));
         chk("rnd_memrw", 32'(mem_rw), 32'(x_rw));
         chk("rnd_cpu_ack", 32'(cpu_ack), 32'(x_cack));
         chk("rnd_io_ack", 32'(io_ack), 32'(x_iack));
         chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(ecr));
         chk("rnd_io_rdata", 32'(io_rdata), 32'(eir));
         if (act && e < g_e + ACC) begin
            chk("rnd_memaddr", 32'(mem_addr), 32'(c_addr));
            if (c_rw) chk("rnd_memd", 32'(mem_d), 32'(c_wd));
         end
         if (cpu_ack) cpu_req = 1'b0;
         if (io_ack)  io_req  = 1'b0;
         if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1; cpu_rw = 1'($urandom_range(0, 1));
            cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
         end
         if (!io_req && $urandom_range(0, 2) == 0) begin
            io_req = 1'b1; io_rw = 1'($urandom_range(0, 1));
            io_addr = 8'($urandom_range(0, 15)); io_wdata = 16'($urandom);
         end
      end
      cpu_req = 1'b0; io_req = 1'b0;
   endtask

   initial begin
      txn_t tbl[9];
      int   n, n2, bad;
      bit   got;
      tbl[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
      tbl[1] = '{1'b1, 1'b1, 8'h80, 16'h1234, 16'h2020};
      tbl[2] = '{1'b0, 1'b0, 8'h80, 16'h0000, 16'h1234};
      tbl[3] = '{1'b0, 1'b1, 8'h10, 16'hA5A5, 16'h1234};
      tbl[4] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
      tbl[5] = '{1'b1, 1'b1, 8'hFF, 16'hFFFF, 16'hA5A5};
      tbl[6] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
      tbl[7] = '{1'b0, 1'b1, 8'h00, 16'h0001, 16'hFFFF};
      tbl[8] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001};

      rst = 1'b0; ram_clear = 1'b1;
      cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 8'h0; cpu_wdata = 16'h0;
      io_req = 1'b0;  io_rw = 1'b0;  io_addr = 8'h0;  io_wdata = 16'h0;
      p_cpu_req = 1'b0; p_cpu_rw = 1'b0; p_cpu_addr = 8'h0; p_cpu_wdata = 16'h0;
      p_io_req = 1'b0;  p_io_rw = 1'b0;  p_io_addr = 8'h0;  p_io_wdata = 16'h0;

      // reset held for 3 cycles with a pending CPU request
      cpu_addr = 8'h10; cpu_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         ram_clear = 1'b0;
         chk("rst_acks", 32'({cpu_ack, io_ack}), 32'd0);
         chk("rst_memrw", 32'(mem_rw), 32'd0);
         chk("rst_memaddr", 32'(mem_addr), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rdata", 32'({cpu_rdata, io_rdata}), 32'd0);
      end
      rst = 1'b1;
      io_addr = 8'h20; io_req = 1'b1;
      tick();
      chk("first_grant_busy", 32'(busy), 32'd1);
      chk("first_grant_cpu", 32'(mem_addr), 32'h10);
      wait_ack(1'b0, 10, n, got);
      chk("first_cpu_ack", 32'(got), 32'd1);
      chk("first_cpu_lat", 32'(n), 32'(ACC));
      chk("first_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
      cpu_req = 1'b0;
      wait_ack(1'b1, 12, n, got);
      chk("then_io_ack", 32'(got), 32'd1);
      chk("then_io_lat", 32'(n), 32'(ACC + 2));
      chk("then_io_rdata", 32'(io_rdata), 32'h2020);
      io_req = 1'b0;
      tick();
      tick();

      for (int i = 0; i < 9; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

      run_tie();

      // CPU keeps the same request up through its ack cycle
      cpu_rw = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
      wait_ack(1'b0, 10, n, got);
      chk("held_first_ack", 32'(got), 32'd1);
      tick();
      chk("held_done_ack", 32'(cpu_ack), 32'd0);
      chk("held_done_idle", 32'(busy), 32'd0);
      tick();
      chk("held_regrant", 32'(busy), 32'd1);
      wait_ack(1'b0, 10, n2, got);
      chk("held_second_ack", 32'(got), 32'd1);
      chk("held_second_lat", 32'(n2), 32'(ACC));
      chk("held_rdata", 32'(cpu_rdata), 32'hA5A5);
      cpu_req = 1'b0;
      tick();

      // reset while an IO write is in flight
      io_rw = 1'b1; io_addr = 8'h40; io_wdata = 16'h5555; io_req = 1'b1;
      tick();
      chk("midrst_memrw_before", 32'(mem_rw), 32'd1);
      rst = 1'b0;
      tick();
      chk("midrst_memrw", 32'(mem_rw), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_io_ack", 32'(io_ack), 32'd0);
      rst = 1'b1; io_req = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (io_ack || busy) bad++;
      end
      chk("midrst_no_ack_after", 32'(bad), 32'd0);
      do_txn("post_rst", '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hA5A5});

      rst = 1'b0;
      tick();
      rst = 1'b1;
      run_random();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
